// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with 16x oversampled start/data/stop framing and a registered line output.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] S_BIT  = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t          state, state_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic            tx_n, done_n;
    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        done_n  = 1'b0;
        case (state)
            IDLE: if (tx_start) begin
                state_n = START;
                s_n     = '0;
                b_n     = din[DBIT-1:0];
            end
            START: if (s_tick) begin
                if (s == S_BIT) begin
                    state_n = DATA;
                    s_n     = '0;
                    n_n     = '0;
                end else s_n = s + 1'b1;
            end
            DATA: if (s_tick) begin
                if (s == S_BIT) begin
                    s_n = '0;
                    b_n = b >> 1;
                    if (n == N_LAST) state_n = STOP;
                    else n_n = n + 1'b1;
                end else s_n = s + 1'b1;
            end
            STOP: if (s_tick) begin
                if (s == S_STOP) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else s_n = s + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // line level follows the state being entered so tx is a clean register output
        tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? b_n[0] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            tx           <= tx_n;
            tx_done_tick <= done_n;
        end
    end
    assign tx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; stimulus queues expected frames, a negedge monitor checks the line cycle by cycle.
module tb_uart_tx;
    logic       clk = 1'b0, rst = 1'b1, s_tick = 1'b0, tx_start = 1'b0, tx_start2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx, tx_busy, tx_done_tick, tx2, tx_busy2, tx_done_tick2;
    int         checks = 0, errors = 0, period = 1, tcnt = 0;
    typedef struct { logic [7:0] d; int cyc; int gap; } exp_t;
    exp_t       q[$];
    exp_t       cur;
    logic       active = 1'b0, prev_busy = 1'b0, rst_d = 1'b0, exp_bit;
    int         t = 0, cyc = 0, idle = 0;
    int         len2, mis2, ones2, dn2;
    logic [7:0] d2;
    logic       e2;

    uart_tx dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );
    uart_tx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start2), .din(din),
        .tx(tx2), .tx_busy(tx_busy2), .tx_done_tick(tx_done_tick2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            s_tick = (tcnt == 0);
            tcnt = (tcnt + 1 >= period) ? 0 : tcnt + 1;
        end
    end

    // monitor: pops one expectation per busy rising edge and checks every cycle of the frame
    always @(negedge clk) begin
        if (rst) begin
            active    = 1'b0;
            rst_d     = 1'b1;
            prev_busy = 1'b0;
            idle      = 0;
        end else begin
            if (rst_d) begin
                chk("rst_tx", tx, 1);
                chk("rst_busy", tx_busy, 0);
                chk("rst_done", tx_done_tick, 0);
            end
            rst_d = 1'b0;
            if (tx_done_tick) begin
                chk("done_busy_low", tx_busy, 0);
                chk("done_after_busy", prev_busy, 1);
                if (!active) chk("done_unexpected", 1, 0);
                else begin
                    chk("frame_ticks", t, 160);
                    if (cur.cyc >= 0) chk("frame_cycles", cyc, cur.cyc);
                    active = 1'b0;
                end
            end
            if (tx_busy && !prev_busy) begin
                if (q.size() == 0) chk("frame_unexpected", 1, 0);
                else begin
                    cur = q.pop_front();
                    active = 1'b1;
                    t = 0;
                    cyc = 0;
                    if (cur.gap >= 0) chk("idle_gap", idle, cur.gap);
                end
            end
            if (tx_busy && active) begin
                exp_bit = (t < 16) ? 1'b0 : (t < 144) ? cur.d[(t - 16) / 16] : 1'b1;
                chk("tx_level", tx, exp_bit);
                cyc++;
                if (s_tick) t++;
            end
            if (!tx_busy) begin
                chk("idle_tx", tx, 1);
                idle++;
            end else idle = 0;
            prev_busy = tx_busy;
        end
    end

    task automatic send(input logic [7:0] d, input int c, input bit align);
        q.push_back('{d, c, -1});
        @(posedge clk);
        #2;
        if (align) for (int i = 0; i < 64 && !s_tick; i++) begin
            @(posedge clk);
            #2;
        end
        din = d;
        tx_start = 1'b1;
        @(posedge clk);
        #2;
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #3;
            if (q.size() == 0 && !active && !tx_busy) begin
                repeat (3) @(posedge clk);
                #2;
                return;
            end
        end
        chk(name, 1, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tx_start = 1'b1;
        din = 8'hFF;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        tx_start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        send(8'hA5, 160, 1'b0);
        wait_idle("timeout_a5", 400);
        period = 4;
        send(8'h00, 640, 1'b1);
        wait_idle("timeout_00", 1500);
        period = 3;
        send(8'hC3, -1, 1'b0);
        wait_idle("timeout_c3", 1000);
        period = 1;
        send(8'h3C, 160, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        din = 8'hFF;
        tx_start = 1'b1;
        @(posedge clk);
        #2;
        tx_start = 1'b0;
        wait_idle("timeout_3c", 400);
        q.push_back('{8'h55, 160, -1});
        q.push_back('{8'h55, 160, 1});
        q.push_back('{8'h55, 160, 1});
        @(posedge clk);
        #2;
        din = 8'h55;
        tx_start = 1'b1;
        for (int i = 0; i < 1000 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        repeat (20) @(posedge clk);
        #2;
        tx_start = 1'b0;
        wait_idle("timeout_b2b", 400);
        send(8'h5A, -1, 1'b0);
        repeat (72) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_idle("timeout_abort", 50);
        send(8'h81, 160, 1'b0);
        wait_idle("timeout_81", 400);
        d2 = 8'h01;
        len2 = 0;
        mis2 = 0;
        ones2 = 0;
        dn2 = 0;
        @(posedge clk);
        #2;
        din = d2;
        tx_start2 = 1'b1;
        @(posedge clk);
        #2;
        tx_start2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_done_tick2) dn2++;
            if (tx_busy2) begin
                e2 = (len2 < 16) ? 1'b0 : (len2 < 144) ? d2[(len2 - 16) / 16] : 1'b1;
                if (tx2 !== e2) mis2++;
                if (len2 >= 144 && tx2 === 1'b1) ones2++;
                len2++;
            end
        end
        chk("sb32_frame_len", len2, 176);
        chk("sb32_level_errs", mis2, 0);
        chk("sb32_stop_len", ones2, 32);
        chk("sb32_done_count", dn2, 1);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8, meaning number of data bits per frame (legal 5..8).
REQ-002 Parameter SB_TICK, default 16, meaning stop-bit length in s_tick pulses (16/24/32 = 1/1.5/2 stop bits).
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port s_tick  input  1  16x-oversampling enable pulse, one clk wide (driven by mod_m_cnt max_tic).
REQ-006 Port tx_start  input  1  request to send din; sampled only in IDLE.
REQ-007 Port din  input  8  data byte; bits [DBIT-1:0] transmitted, LSB first.
REQ-008 Port tx  output  1  serial line, registered, idles high.
REQ-009 Port tx_busy  output  1  high whenever state is not IDLE.
REQ-010 Port tx_done_tick  output  1  one-clk pulse marking frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP; encoding is free.
REQ-012 Internal regs SHALL be: tick count s (4 bits, or wide enough for SB_TICK-1), bit count n ($clog2(DBIT) bits), shift reg b (DBIT bits).
REQ-013 IDLE: tx=1; when tx_start=1 at a clk edge, SHALL latch din into b, clear s, go START; tx=0 from the next cycle.
REQ-014 An s_tick coincident with the accepting tx_start SHALL NOT be counted; counting starts on the next cycle.
REQ-015 s, n and state SHALL change only on cycles with s_tick=1 (except REQ-013 acceptance and reset); s_tick=0 cycles hold all state.
REQ-016 START: tx=0; on s_tick with s==15, clear s, clear n, go DATA; else s+1.
REQ-017 DATA: tx=b[0]; on s_tick with s==15, clear s, shift b right by one, and if n==DBIT-1 go STOP, else n+1.
REQ-018 STOP: tx=1; on s_tick with s==SB_TICK-1, go IDLE and assert tx_done_tick for exactly the next cycle; else s+1.
REQ-019 Frame length SHALL be exactly 16*(1+DBIT)+SB_TICK s_tick pulses (160 for defaults).
REQ-020 tx_start while not IDLE SHALL be ignored; no queuing; din changes after acceptance SHALL NOT affect the frame.
REQ-021 tx_start high during the tx_done_tick cycle (first IDLE cycle) SHALL be accepted: back-to-back frames have no idle gap beyond that cycle.
REQ-022 tx SHALL be glitch-free: driven from a register updated only at clk edges.
REQ-023 tx_busy SHALL be 0 in the same cycle tx_done_tick is 1.

Reset
REQ-024 On rst=1 at a clk edge: state=IDLE, s=0, n=0, b=0, tx=1, tx_busy=0, tx_done_tick=0, from the following cycle.
REQ-025 rst mid-frame SHALL abort the frame with no tx_done_tick; rst SHALL override a simultaneous tx_start.
REQ-026 After rst deasserts, the first tx_start in IDLE SHALL start a normal frame.

Verification
REQ-027 s_tick=1 every cycle, din=8'hA5, tx_start one cycle -> tx = 0, 1,0,1,0,0,1,0,1, then 1; each level 16 cycles, total 160 busy cycles, one tx_done_tick.
REQ-028 s_tick every 4th clk (mod_m_cnt M=4), din=8'h00 -> start plus 8 data bits low for 576 cycles, stop high 64 cycles, tx_done_tick once.
REQ-029 tx_start re-pulsed with din=8'hFF during DATA of an 8'h3C frame -> line shows 8'h3C only, single tx_done_tick.
REQ-030 tx_start held high continuously, din=8'h55 -> consecutive frames separated by exactly one IDLE cycle (the tx_done_tick cycle), one done pulse per frame.
REQ-031 rst pulsed at bit 3 of DATA -> tx=1, tx_busy=0 next cycle, no tx_done_tick; subsequent din=8'h81 frame correct.
REQ-032 SB_TICK=32 build, din=8'h01 -> stop level high for 32 s_tick pulses, frame 176 pulses.
